mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shared single-port word memory serving `NUM_PORTS` requesters through a per-port req/gnt/rvalid handshake. It replaces the separate instruction and data memories for the multicycle and pipelined cores. Port 0 is instruction fetch and port 1 is data by convention. Provides byte-lane writes, registered reads, an out-of-range error response, and compile-time selectable arbitration.

## Interface
Parameters:
- `NUM_PORTS`, 2, number of requester ports (≥1).
- `DEPTH_WORDS`, 1024, memory depth in 32-bit words (power of two).
- `IDX_W`, `$clog2(DEPTH_WORDS)`, word-index width (derived, not overridden).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `req[NUM_PORTS]` in 1 each: request valid.
- `we[NUM_PORTS]` in 1 each: 1 = write, 0 = read.
- `be[NUM_PORTS]` in 4 each: byte-lane enables for writes; ignored on reads.
- `addr[NUM_PORTS]` in `word_t`: byte address; bits [1:0] ignored.
- `wdata[NUM_PORTS]` in `word_t`: write data.
- `gnt[NUM_PORTS]` out 1 each: request accepted this cycle (combinational).
- `rvalid[NUM_PORTS]` out 1 each: response valid.
- `rdata[NUM_PORTS]` out `word_t`: read data, qualified by `rvalid`.
- `err[NUM_PORTS]` out 1 each: out-of-range response, qualified by `rvalid`.

## Operation
- At most one `gnt` bit per cycle, and only to a port with `req`=1.
- The requester holds `req`, `we`, `be`, `addr` and `wdata` stable until it sees `gnt`. It may drop `req` after the grant or keep it high to issue a new request the next cycle.
- Index = `addr[IDX_W+1:2]`. Any `addr[31:IDX_W+2]` ≠ 0 means out of range.
- Granted write, in range: each lane `i` with `be[i]`=1 takes `wdata[8i+7:8i]`; other lanes unchanged.
- Granted read, in range: returns the full word as it was before any write in the same cycle. A same-port write then read in back-to-back cycles sees the new data.
- Out of range: no memory change. The response has `err`=1 and `rdata`=0.
- Every grant produces exactly one response on the granted port: reads and writes alike. Writes return `rdata`=0 and `err` per range check.
- Response registers: `resp_valid`, `resp_port`, `resp_err`, plus the RAM read register. `rvalid[p]` = `resp_valid && resp_port==p`. Non-selected ports drive `rdata`=0 and `err`=0.
- Arbitration state: pointer `last_gnt` (`$clog2(NUM_PORTS)` bits, min 1). It updates to the granted index on each grant and holds when there is no grant.
- RAM contents are not reset (X until written).

## Timing
- Grant in cycle T, same cycle as `req`, zero wait states.
- Response in cycle T+1 (`rvalid` high exactly one cycle).
- Back-to-back grants: one per cycle sustained, to any mix of ports.
- Reset values: `gnt`=0 (forced while `reset`=1), `rvalid`=0, `rdata`=0, `err`=0, `last_gnt`=`NUM_PORTS-1`, `resp_valid`=0.
- Reset mid-operation:
  - A grant in the cycle reset asserts is void, with no write and no response.
  - A response pending for T+1 is cleared.
  - The first grant after deassertion follows the reset pointer.
- `NUM_PORTS`=1: the arbiter degenerates to `gnt[0]=req[0]`.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin. The search starts at `(last_gnt+1) mod NUM_PORTS` and the first requesting port wins.
  - Continuous requests from all ports are served in rotation.
  - After reset, port 0 wins first.
- Undefined:
  - Fixed priority, lowest index wins.
  - `last_gnt` is still maintained but does not affect selection.
  - Port 0 can starve others.

## Structure
- `types_pkg`:
  - Already holds `word_t` and `address_t`.
  - Add `mem_req_t` (we, be, addr, wdata) and `mem_rsp_t` (rvalid, rdata, err).
  - Add `BE_WIDTH`=4.
  - Port arrays may be packed from these.
- One sub-module, `shared_ram`:
  - Parameters `DEPTH_WORDS`.
  - Ports `clk`, `en`, `we`, `be`, `idx`, `wdata`, `rdata`.
  - Registered read, byte-lane write, read-before-write.
- Arbitration, range check and response steering stay in `mem_arbiter`.

## Test plan
- Reset: hold `reset` 3 cycles with random `req` → all `gnt`, `rvalid`, `rdata`, `err` = 0 throughout; contents untouched.
- Write then read:
  - Port 1 writes 0xDEADBEEF to 0x10 with `be`=1111 → `gnt[1]` same cycle, `rvalid[1]` T+1 with `rdata`=0.
  - Port 0 then reads 0x10 → `rvalid[0]` next cycle, `rdata`=0xDEADBEEF.
- Byte lanes: port 1 writes 0x0000AA00 to 0x10 with `be`=0010 → a subsequent read returns 0xDEADAAEF.
- Contention: both ports request reads every cycle for 6 cycles.
  - With the macro, grants go 0,1,0,1,0,1.
  - Without the macro, grants go 0,0,0,0,0,0 and `gnt[1]` stays 0.
- Out of range: port 0 writes to byte address `DEPTH_WORDS*4` → `gnt[0]`, then `rvalid[0]`=1 with `err`=1 and `rdata`=0. Reading word 0 shows it unchanged.
- Reset mid-op: grant a write of 0x12345678 to 0x20 (previously 0) and assert `reset` in the same cycle → no `rvalid` afterwards, and word 0x20 still reads 0 after release.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the memory subsystem: word/address types, request and
// response bundles, and the byte-enable width.
package types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] address_t;

    localparam int BE_WIDTH = 4;

    typedef struct packed {
        logic                we;
        logic [BE_WIDTH-1:0] be;
        address_t            addr;
        word_t               wdata;
    } mem_req_t;

    typedef struct packed {
        logic  rvalid;
        word_t rdata;
        logic  err;
    } mem_rsp_t;

endpackage

// File: rtl/shared_ram.sv
// Single-port word RAM: registered read, byte-lane write, read-before-write.
// Ports: clk, en, we, be (lane enables), idx (word index), wdata, rdata.
module shared_ram
    import types_pkg::*;
#(
    parameter  int DEPTH_WORDS = 1024,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [BE_WIDTH-1:0] be,
    input  logic [IDX_W-1:0]    idx,
    input  word_t               wdata,
    output word_t               rdata
);

    word_t mem [DEPTH_WORDS];

    // The read register samples the old word even when the same access
    // writes it, so a write returns pre-write contents internally.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[idx];
            if (we) begin
                for (int i = 0; i < BE_WIDTH; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shared word memory arbitrated across NUM_PORTS req/gnt/rvalid requesters.
// Ports: clk, reset (async high); per-port req/we/be/addr/wdata in;
// gnt (combinational), rvalid/rdata/err (registered, one cycle after gnt).
// Macro MEM_ARB_ROUND_ROBIN_EN selects round-robin; default fixed priority.
module mem_arbiter
    import types_pkg::*;
#(
    parameter  int NUM_PORTS   = 2,
    parameter  int DEPTH_WORDS = 1024,
    localparam int IDX_W       = $clog2(DEPTH_WORDS),
    localparam int PW          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_PORTS-1:0]               req,
    input  logic [NUM_PORTS-1:0]               we,
    input  logic [NUM_PORTS-1:0][BE_WIDTH-1:0] be,
    input  word_t [NUM_PORTS-1:0]              addr,
    input  word_t [NUM_PORTS-1:0]              wdata,
    output logic [NUM_PORTS-1:0]               gnt,
    output logic [NUM_PORTS-1:0]               rvalid,
    output word_t [NUM_PORTS-1:0]              rdata,
    output logic [NUM_PORTS-1:0]               err
);

    logic [PW-1:0] last_gnt;
    logic [PW-1:0] sel;
    logic          any;
    logic          fire;
    logic          in_range;
    mem_req_t      cur;

    logic          resp_valid;
    logic [PW-1:0] resp_port;
    logic          resp_err;
    logic          resp_rd;
    word_t         ram_rdata;

    logic          unused_addr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    int dist;
    int best;

    // Winner is the requester closest after last_gnt in rotation order.
    always_comb begin
        sel  = '0;
        any  = 1'b0;
        dist = 0;
        best = NUM_PORTS;
        for (int p = 0; p < NUM_PORTS; p++) begin
            dist = (p + NUM_PORTS - 1 - int'(last_gnt)) % NUM_PORTS;
            if (req[p] && dist < best) begin
                best = dist;
                sel  = PW'(p);
                any  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        sel = '0;
        any = 1'b0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (req[p]) begin
                sel = PW'(p);
                any = 1'b1;
            end
        end
    end
`endif

    assign cur = '{
        we:    we[sel],
        be:    be[sel],
        addr:  addr[sel],
        wdata: wdata[sel]
    };

    // A grant during reset is void: no gnt, no RAM access, no response.
    assign fire        = any && !reset;
    assign in_range    = (cur.addr >> (IDX_W + 2)) == '0;
    assign unused_addr = ^cur.addr[1:0];

    always_comb begin
        gnt = '0;
        if (fire) begin
            gnt[sel] = 1'b1;
        end
    end

    shared_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .en    (fire && in_range),
        .we    (cur.we),
        .be    (cur.be),
        .idx   (cur.addr[IDX_W+1:2]),
        .wdata (cur.wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_port  <= '0;
            resp_err   <= 1'b0;
            resp_rd    <= 1'b0;
            last_gnt   <= PW'(NUM_PORTS - 1);
        end else begin
            resp_valid <= fire;
            if (fire) begin
                resp_port <= sel;
                resp_err  <= !in_range;
                resp_rd   <= !cur.we;
                last_gnt  <= sel;
            end
        end
    end

    // Only reads that hit memory expose RAM data; writes and errors read 0.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rvalid[p] = resp_valid && (resp_port == PW'(p));
            err[p]    = rvalid[p] && resp_err;
            rdata[p]  = (rvalid[p] && resp_rd && !resp_err) ? ram_rdata : '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a behavioural
// memory/arbitration model; honours MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

    localparam int NP = 2;
    localparam int DW = 1024;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NP-1:0]          req, we;
    logic [NP-1:0][3:0]     be;
    logic [NP-1:0][31:0]    addr, wdata;
    logic [NP-1:0]          gnt, rvalid, err;
    logic [NP-1:0][31:0]    rdata;

    mem_arbiter #(.NUM_PORTS(NP), .DEPTH_WORDS(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .be(be),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // requester-side intent
    bit          r_req   [NP];
    bit          r_we    [NP];
    logic [3:0]  r_be    [NP];
    logic [31:0] r_addr  [NP];
    logic [31:0] r_wdata [NP];

    // reference model
    logic [31:0] mmem [DW];
    int          mptr;
    bit          pv;
    int          pp;
    bit          perr;
    logic [31:0] prd;
    int          win;
    logic [NP-1:0] gnt_seen;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NP; k++) begin
            if (r_req[(mptr + k) % NP]) return (mptr + k) % NP;
        end
`else
        for (int p = 0; p < NP; p++) begin
            if (r_req[p]) return p;
        end
`endif
        return -1;
    endfunction

    task automatic set_req(input int p, input bit w, input logic [3:0] b,
                           input logic [31:0] a, input logic [31:0] d);
        r_req[p]   = 1'b1;
        r_we[p]    = w;
        r_be[p]    = b;
        r_addr[p]  = a;
        r_wdata[p] = d;
    endtask

    task automatic clear_reqs();
        for (int p = 0; p < NP; p++) r_req[p] = 1'b0;
    endtask

    task automatic rand_req(input int p);
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0)
            a = DW * 4 + ($urandom & 32'h0FFF_FFFF);
        else
            a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
        set_req(p, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
    endtask

    // One clock: drive at negedge, check just after, update model at posedge.
    task automatic step(input bit rst_v);
        int          w;
        int          ix;
        bit          oor;
        logic [NP-1:0] eg;
        @(negedge clk);
        reset = rst_v;
        for (int p = 0; p < NP; p++) begin
            req[p]   = r_req[p];
            we[p]    = r_we[p];
            be[p]    = r_be[p];
            addr[p]  = r_addr[p];
            wdata[p] = r_wdata[p];
        end
        if (rst_v) begin
            pv   = 1'b0;
            mptr = NP - 1;
        end
        w = rst_v ? -1 : pick();
        #1;
        gnt_seen = gnt;
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        for (int p = 0; p < NP; p++) begin
            chk("rvalid", 32'(rvalid[p]), 32'(pv && pp == p));
            chk("rdata", rdata[p], (pv && pp == p) ? prd : 32'h0);
            chk("err", 32'(err[p]), 32'(pv && pp == p && perr));
        end
        @(posedge clk);
        pv = 1'b0;
        if (w >= 0) begin
            oor  = r_addr[w] >= 32'(DW * 4);
            ix   = int'((r_addr[w] >> 2) % DW);
            pv   = 1'b1;
            pp   = w;
            mptr = w;
            perr = oor;
            prd  = (!r_we[w] && !oor) ? mmem[ix] : 32'h0;
            if (r_we[w] && !oor) begin
                for (int i = 0; i < 4; i++)
                    if (r_be[w][i]) mmem[ix][8*i +: 8] = r_wdata[w][8*i +: 8];
            end
        end
        win = w;
    endtask

    initial begin
        logic [NP-1:0] exp_g;
        reset = 1'b1;
        req = '0; we = '0; be = '0; addr = '0; wdata = '0;
        mptr = NP - 1;
        pv = 1'b0; pp = 0; perr = 1'b0; prd = '0; win = -1;
        clear_reqs();
        for (int p = 0; p < NP; p++) begin
            r_we[p] = 1'b0; r_be[p] = '0; r_addr[p] = '0; r_wdata[p] = '0;
        end

        // reset held 3 cycles with random traffic
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < NP; p++) begin
                rand_req(p);
                r_req[p] = 1'($urandom_range(0, 1));
            end
            step(1'b1);
        end
        clear_reqs();

        // zero the words used below
        for (int i = 0; i < 16; i++) begin
            set_req(1, 1'b1, 4'hF, 32'(i * 4), 32'h0);
            step(1'b0);
            clear_reqs();
        end

        set_req(1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        step(1'b0);
        clear_reqs();
        #1;
        chk("wr_rvalid1", 32'(rvalid[1]), 32'h1);
        chk("wr_rdata1", rdata[1], 32'h0);

        set_req(0, 1'b0, 4'h0, 32'h10, 32'h0);
        step(1'b0);
        clear_reqs();
        #1;
        chk("rd_rvalid0", 32'(rvalid[0]), 32'h1);
        chk("rd_deadbeef", rdata[0], 32'hDEAD_BEEF);

        set_req(1, 1'b1, 4'b0010, 32'h10, 32'h0000_AA00);
        step(1'b0);
        clear_reqs();
        set_req(0, 1'b0, 4'h0, 32'h10, 32'h0);
        step(1'b0);
        clear_reqs();
        #1;
        chk("byte_lane", rdata[0], 32'hDEAD_AAEF);

        // contention from a freshly reset pointer
        step(1'b1);
        set_req(0, 1'b0, 4'h0, 32'h10, 32'h0);
        set_req(1, 1'b0, 4'h0, 32'h10, 32'h0);
        for (int k = 0; k < 6; k++) begin
            step(1'b0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            chk("contend", 32'(gnt_seen), 32'(exp_g));
        end
        clear_reqs();
        step(1'b0);

        // out of range write, then word 0 unchanged
        set_req(0, 1'b1, 4'hF, 32'(DW * 4), 32'hFFFF_FFFF);
        step(1'b0);
        clear_reqs();
        #1;
        chk("oor_rvalid", 32'(rvalid[0]), 32'h1);
        chk("oor_err", 32'(err[0]), 32'h1);
        chk("oor_rdata", rdata[0], 32'h0);
        set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0);
        clear_reqs();
        #1;
        chk("word0_rdata", rdata[0], 32'h0);
        chk("word0_err", 32'(err[0]), 32'h0);

        // reset asserted in the grant cycle voids the write
        set_req(1, 1'b1, 4'hF, 32'h20, 32'h1234_5678);
        step(1'b1);
        clear_reqs();
        step(1'b0);
        #1;
        chk("rst_no_rvalid", 32'(rvalid), 32'h0);
        set_req(0, 1'b0, 4'h0, 32'h20, 32'h0);
        step(1'b0);
        clear_reqs();
        #1;
        chk("rst_word20", rdata[0], 32'h0);

        // random traffic with occasional reset
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < NP; p++)
                if (!r_req[p] && $urandom_range(0, 9) < 6) rand_req(p);
            step($urandom_range(0, 99) == 0);
            if (win >= 0) begin
                r_req[win] = 1'b0;
                if ($urandom_range(0, 9) < 5) rand_req(win);
            end
        end
        clear_reqs();
        step(1'b0);
        step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
